// File: rtl/tlul_tracker_pkg.sv
// tlul_tracker_pkg: shared TL-UL opcodes, field widths and the A-channel beat record
package tlul_tracker_pkg;
   localparam int SOURCE_W = 9;
   localparam int ADDR_W   = 36;
   localparam int DATA_W   = 256;
   localparam int MASK_W   = 32;
   localparam logic [2:0] A_PUT_FULL_DATA    = 3'd0;
   localparam logic [2:0] A_PUT_PARTIAL_DATA = 3'd1;
   localparam logic [2:0] A_GET              = 3'd4;
   localparam logic [2:0] D_ACCESS_ACK       = 3'd0;
   localparam logic [2:0] D_ACCESS_ACK_DATA  = 3'd1;
   typedef struct packed {
      logic [2:0]          opcode;
      logic [2:0]          size;
      logic [SOURCE_W-1:0] source;
      logic [ADDR_W-1:0]   address;
      logic [MASK_W-1:0]   mask;
      logic [DATA_W-1:0]   data;
   } tl_a_beat_t;
endpackage

// File: rtl/tlul_tracker_fifo.sv
// tlul_tracker_fifo: registered FIFO of A-channel beats, no bypass
//   clock, reset : clock, synchronous active-high reset
//   push, wdata  : write a beat (caller guarantees !full)
//   pop, rdata   : drop the head beat / current head (caller guarantees !empty)
//   full, empty  : occupancy flags from registered pointers
module tlul_tracker_fifo import tlul_tracker_pkg::*; #(
   parameter int DEPTH = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push,
   input  tl_a_beat_t wdata,
   input  logic       pop,
   output tl_a_beat_t rdata,
   output logic       full,
   output logic       empty
);
   localparam int PTR_W = $clog2(DEPTH);
   tl_a_beat_t mem_q [DEPTH];
   tl_a_beat_t mem_d [DEPTH];
   logic [PTR_W:0] wr_q, wr_d, rd_q, rd_d;
   always_comb begin
      mem_d = mem_q;
      if (push) mem_d[wr_q[PTR_W-1:0]] = wdata;
      wr_d  = wr_q + {{PTR_W{1'b0}}, push};
      rd_d  = rd_q + {{PTR_W{1'b0}}, pop};
      rdata = mem_q[rd_q[PTR_W-1:0]];
      empty = wr_q == rd_q;
      full  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
      end
   end
   always_ff @(posedge clock) mem_q <= mem_d;
endmodule

// File: rtl/tlul_req_tracker.sv
// tlul_req_tracker: TL-UL A-channel buffer with in-flight source tracking and sticky protocol error flags
//   clock, reset              : clock, synchronous active-high reset
//   in_a_* / out_a_*          : A channel from adapter, buffered, toward L2
//   in_d_* / out_d_*          : D channel from L2, combinational pass-through toward adapter
//   inflight_cnt              : number of occupied tracker entries
//   err_unexpected_d, err_opcode, err_size, err_timeout : sticky error flags
//   Optional: define TLUL_TRACKER_TIMEOUT_EN for per-entry age counters driving err_timeout
module tlul_req_tracker import tlul_tracker_pkg::*; #(
   parameter int DEPTH          = 4,
   parameter int MAX_INFLIGHT   = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  in_a_valid,
   output logic                                  in_a_ready,
   input  logic [2:0]                            in_a_opcode,
   input  logic [2:0]                            in_a_size,
   input  logic [SOURCE_W-1:0]                   in_a_source,
   input  logic [ADDR_W-1:0]                     in_a_address,
   input  logic [MASK_W-1:0]                     in_a_mask,
   input  logic [DATA_W-1:0]                     in_a_data,
   output logic                                  out_a_valid,
   input  logic                                  out_a_ready,
   output logic [2:0]                            out_a_opcode,
   output logic [2:0]                            out_a_size,
   output logic [SOURCE_W-1:0]                   out_a_source,
   output logic [ADDR_W-1:0]                     out_a_address,
   output logic [MASK_W-1:0]                     out_a_mask,
   output logic [DATA_W-1:0]                     out_a_data,
   input  logic                                  in_d_valid,
   output logic                                  in_d_ready,
   input  logic [2:0]                            in_d_opcode,
   input  logic [2:0]                            in_d_size,
   input  logic [SOURCE_W-1:0]                   in_d_source,
   input  logic                                  in_d_denied,
   input  logic [DATA_W-1:0]                     in_d_data,
   input  logic                                  in_d_corrupt,
   output logic                                  out_d_valid,
   input  logic                                  out_d_ready,
   output logic [2:0]                            out_d_opcode,
   output logic [2:0]                            out_d_size,
   output logic [SOURCE_W-1:0]                   out_d_source,
   output logic                                  out_d_denied,
   output logic [DATA_W-1:0]                     out_d_data,
   output logic                                  out_d_corrupt,
   output logic [$clog2(MAX_INFLIGHT+1)-1:0]     inflight_cnt,
   output logic                                  err_unexpected_d,
   output logic                                  err_opcode,
   output logic                                  err_size,
   output logic                                  err_timeout
);
   localparam int IDX_W = $clog2(MAX_INFLIGHT);
   localparam int CNT_W = $clog2(MAX_INFLIGHT+1);
   tl_a_beat_t in_beat, head;
   logic fifo_full, fifo_empty, a_push, a_pop, d_fire;
   logic src_hit, d_hit, table_full;
   logic [IDX_W-1:0] free_idx, d_idx;
   logic [MAX_INFLIGHT-1:0] valid_q, valid_d, exp_q, exp_d;
   logic [SOURCE_W-1:0] src_q [MAX_INFLIGHT];
   logic [SOURCE_W-1:0] src_d [MAX_INFLIGHT];
   logic err_unexp_q, err_unexp_d, err_op_q, err_op_d, err_size_q, err_size_d;
   assign in_beat      = '{opcode: in_a_opcode, size: in_a_size, source: in_a_source,
                           address: in_a_address, mask: in_a_mask, data: in_a_data};
   assign in_a_ready   = !fifo_full;
   assign a_push       = in_a_valid && !fifo_full;
   assign out_a_opcode  = head.opcode;
   assign out_a_size    = head.size;
   assign out_a_source  = head.source;
   assign out_a_address = head.address;
   assign out_a_mask    = head.mask;
   assign out_a_data    = head.data;
   assign out_d_valid   = in_d_valid;
   assign in_d_ready    = out_d_ready;
   assign out_d_opcode  = in_d_opcode;
   assign out_d_size    = in_d_size;
   assign out_d_source  = in_d_source;
   assign out_d_denied  = in_d_denied;
   assign out_d_data    = in_d_data;
   assign out_d_corrupt = in_d_corrupt;
   assign d_fire        = in_d_valid && out_d_ready;
   assign err_unexpected_d = err_unexp_q;
   assign err_opcode       = err_op_q;
   assign err_size         = err_size_q;
   tlul_tracker_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (a_push),
      .wdata (in_beat),
      .pop   (a_pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
   // Source hits look only at the registered table, so a same-cycle retire
   // never unblocks a dispatch of that source until the following cycle.
   always_comb begin
      src_hit      = 1'b0;
      d_hit        = 1'b0;
      d_idx        = '0;
      free_idx     = '0;
      inflight_cnt = '0;
      for (int i = MAX_INFLIGHT-1; i >= 0; i--) begin
         if (valid_q[i] && src_q[i] == head.source) src_hit = 1'b1;
         if (valid_q[i] && src_q[i] == in_d_source) begin
            d_hit = 1'b1;
            d_idx = IDX_W'(i);
         end
         if (!valid_q[i]) free_idx = IDX_W'(i);
         inflight_cnt = inflight_cnt + CNT_W'(valid_q[i]);
      end
      table_full  = &valid_q;
      out_a_valid = !fifo_empty && !table_full && !src_hit;
      a_pop       = out_a_valid && out_a_ready;
      valid_d     = valid_q;
      exp_d       = exp_q;
      src_d       = src_q;
      if (d_fire && d_hit) valid_d[d_idx] = 1'b0;
      if (a_pop) begin
         valid_d[free_idx] = 1'b1;
         src_d[free_idx]   = head.source;
         exp_d[free_idx]   = head.opcode == A_GET;
      end
      err_op_d    = err_op_q | (d_fire && d_hit &&
                    (exp_q[d_idx] ? in_d_opcode != D_ACCESS_ACK_DATA : in_d_opcode != D_ACCESS_ACK));
      err_unexp_d = err_unexp_q | (d_fire && !d_hit);
      err_size_d  = err_size_q | (a_push && in_a_size > 3'd5);
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q     <= '0;
         exp_q       <= '0;
         for (int i = 0; i < MAX_INFLIGHT; i++) src_q[i] <= '0;
         err_unexp_q <= 1'b0;
         err_op_q    <= 1'b0;
         err_size_q  <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         exp_q       <= exp_d;
         src_q       <= src_d;
         err_unexp_q <= err_unexp_d;
         err_op_q    <= err_op_d;
         err_size_q  <= err_size_d;
      end
   end
`ifdef TLUL_TRACKER_TIMEOUT_EN
   localparam int AGE_W = $clog2(TIMEOUT_CYCLES+1);
   logic [AGE_W-1:0] age_q [MAX_INFLIGHT];
   logic [AGE_W-1:0] age_d [MAX_INFLIGHT];
   logic err_to_q, err_to_d;
   // Ages saturate at the limit; the flag rises in the cycle an entry reaches it.
   always_comb begin
      err_to_d = err_to_q;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
         age_d[i] = (a_pop && free_idx == IDX_W'(i)) ? '0 :
                    (valid_q[i] && age_q[i] != AGE_W'(TIMEOUT_CYCLES)) ? age_q[i] + AGE_W'(1) : age_q[i];
         if (valid_q[i] && age_d[i] == AGE_W'(TIMEOUT_CYCLES)) err_to_d = 1'b1;
      end
   end
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < MAX_INFLIGHT; i++) age_q[i] <= '0;
         err_to_q <= 1'b0;
      end else begin
         age_q    <= age_d;
         err_to_q <= err_to_d;
      end
   end
   assign err_timeout = err_to_q;
`else
   assign err_timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif
endmodule

// File: doc/tlul_req_tracker.md
# tlul_req_tracker

TL-UL request buffer and in-flight tracker sitting directly downstream of the DMA-side AXI4-to-TL adapter and upstream of the L2 client port. Buffers A-channel beats in a small FIFO and records each dispatched source ID. Blocks re-issue of a source still in flight and retires entries on D responses. Flags protocol violations in sticky error bits for the test environment.

## Interface
- DEPTH, 4, A-channel FIFO entries (power of 2, ≥2)
- MAX_INFLIGHT, 16, tracker table entries
- TIMEOUT_CYCLES, 1024, age limit per entry (only with timeout macro)
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high
- in_a_valid / in_a_ready  in/out  1  A from adapter
- in_a_opcode  in  3;  in_a_size  in  3;  in_a_source  in  9;  in_a_address  in  36;  in_a_mask  in  32;  in_a_data  in  256
- out_a_valid / out_a_ready  out/in  1  A toward L2; out_a_opcode/size/source/address/mask/data  out  same widths
- in_d_valid / in_d_ready  in/out  1  D from L2; in_d_opcode 3, in_d_size 3, in_d_source 9, in_d_denied 1, in_d_data 256, in_d_corrupt 1
- out_d_valid / out_d_ready  out/in  1  D toward adapter; out_d_* mirror in_d_*
- inflight_cnt  out  $clog2(MAX_INFLIGHT+1)  occupied table entries
- err_unexpected_d, err_opcode, err_size, err_timeout  out  1 each  sticky flags

## Operation
- A path: in_a fire pushes {opcode,size,source,address,mask,data} into FIFO; in_a_ready = !fifo_full.
- Dispatch gate: out_a_valid = !fifo_empty && !table_full && !src_hit(head.source), where src_hit compares against registered table only.
- out_a fire: pop FIFO; allocate lowest free table entry {valid, source, expect_data = (opcode==Get(4))}; age cleared.
- D path: combinational pass-through (out_d_valid=in_d_valid, in_d_ready=out_d_ready, data fields wired).
- D fire: CAM lookup on in_d_source. Hit → free entry; if expect_data && opcode≠AccessAckData(1), or !expect_data && opcode≠AccessAck(0) → set err_opcode. Miss → set err_unexpected_d, no table change.
- err_size set when in_a fires with size>5 (beat exceeds 256 bits); beat still forwarded.
- Opcodes other than 0,1,4 on A: forwarded, tracked as non-data, no error.
- All error flags sticky until reset.

## Timing
- Reset: in_a_ready=1 after the reset cycle, out_a_valid=0, FIFO empty, table cleared, inflight_cnt=0, all err_*=0. out_d_* follow inputs combinationally throughout.
- A latency: beat accepted in cycle N appears on out_a earliest N+1 (FIFO registered, no bypass).
- FIFO full: in_a_ready=0; simultaneous pop in that cycle does not raise ready until N+1.
- Same-cycle D retire and A dispatch of the same source: dispatch blocked; eligible next cycle.
- Same-cycle alloc (entry i) and free (entry j): both take effect; inflight_cnt unchanged.
- Table full with a D freeing an entry: dispatch waits one cycle.
- out_a_valid, once high, holds with stable payload until out_a_ready (head cannot change without pop; gate inputs only relax except via new allocations, which require that pop).
- Reset asserted mid-transaction: all state cleared in that cycle; late D responses afterwards set err_unexpected_d.

## Configuration
- TLUL_TRACKER_TIMEOUT_EN defined: per-entry age counter ($clog2(TIMEOUT_CYCLES+1) bits, saturating) increments each cycle while valid; reaching TIMEOUT_CYCLES sets err_timeout; entry stays until D retires it.
- Undefined: no age counters; err_timeout tied 0.

## Structure
- Package tlul_tracker_pkg: A/D opcode constants (PutFullData 0, PutPartialData 1, Get 4, AccessAck 0, AccessAckData 1), widths (SOURCE_W 9, ADDR_W 36, DATA_W 256, MASK_W 32), packed struct tl_a_beat_t.
- Sub-module tlul_tracker_fifo: parameterized synchronous FIFO of tl_a_beat_t with full/empty; tracker table lives in the top.

## Test plan
- Get source 0x12 addr 0x8000_0000, D AccessAckData source 0x12 → out_a one cycle after accept, inflight_cnt 1→0, no errors.
- Two Gets source 0x05 back-to-back → second held (out_a_valid=0) until first D fires, dispatched the cycle after.
- 17 distinct sources, out_a_ready=1, no D → 16 dispatched, 17th held, inflight_cnt=16; one D releases it next cycle.
- PutFullData source 0x30 answered with AccessAckData → err_opcode=1, entry freed, flag held until reset.
- D with source 0x1FF never issued → err_unexpected_d=1; A beat with size 6 → err_size=1, beat still forwarded.
- With TLUL_TRACKER_TIMEOUT_EN, TIMEOUT_CYCLES=8: Get unanswered → err_timeout=1 on 8th cycle after dispatch; without macro stays 0.
